// File: rtl/fb_bus_sched_pkg.sv
// Shared types and constants for the framebuffer bus scheduler.
package fb_bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FETCH = 2'd2
    } sched_state_t;

    localparam int FETCH_LAT = 1;

endpackage

// File: rtl/fb_bus_sched.sv
// Single-port framebuffer arbiter: display line fetch (absolute priority) into a
// double-buffered line buffer, with drawing-engine writes filling the idle cycles.
module fb_bus_sched
    import fb_bus_sched_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int V_RES      = 480,
    parameter int LINE_WORDS = 640,
    parameter int FB_ADDRW   = 19,
    parameter int FB_DATAW   = 8,
    parameter int LB_ADDRW   = 10
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    draw_valid,
    output logic                    draw_ready,
    input  logic [FB_ADDRW-1:0]     draw_addr,
    input  logic [FB_DATAW-1:0]     draw_data,
    output logic [FB_ADDRW-1:0]     mem_addr,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [FB_DATAW-1:0]     mem_wdata,
    input  logic [FB_DATAW-1:0]     mem_rdata,
    output logic                    lb_we,
    output logic [LB_ADDRW:0]       lb_addr,
    output logic [FB_DATAW-1:0]     lb_wdata,
    output logic                    fetch_busy,
    output logic                    fetch_err
);

    localparam logic signed [CORDW-1:0] SY_MIN   = -1;
    localparam logic signed [CORDW-1:0] SY_MAX   = CORDW'(V_RES - 2);
    localparam logic [FB_ADDRW-1:0]     LW_A     = FB_ADDRW'(LINE_WORDS);
    localparam logic [LB_ADDRW-1:0]     LAST_IDX = LB_ADDRW'(LINE_WORDS - 1);

    sched_state_t r_state, w_state_nxt;

    logic w_trig, w_overrun, w_hs, w_done;
    logic [FB_ADDRW-1:0] w_start_base;

    logic                r_run;
    logic                r_err;
    logic                r_iss_on;
    logic [LB_ADDRW-1:0] r_iss_idx;
    logic                r_half;
    logic [FB_ADDRW-1:0] r_base;
    logic [FB_ADDRW-1:0] r_cur_base;

    logic                r_mem_re;
    logic                r_mem_we;
    logic [FB_ADDRW-1:0] r_mem_addr;
    logic [FB_DATAW-1:0] r_mem_wdata;
    logic [LB_ADDRW-1:0] r_mem_idx;

    logic [FETCH_LAT-1:0] r_rd_vld;
    logic [LB_ADDRW-1:0]  r_rd_idx [FETCH_LAT];

    logic                r_lb_we;
    logic                r_lb_last;
    logic [LB_ADDRW:0]   r_lb_addr;
    logic [FB_DATAW-1:0] r_lb_wdata;

    assign w_trig       = line && (sy >= SY_MIN) && (sy <= SY_MAX);
    assign w_overrun    = w_trig && (r_state == FETCH);
    assign w_hs         = draw_valid && draw_ready;
    assign w_done       = r_lb_we && r_lb_last;
    // A frame pulse coinciding with a trigger restarts the frame at address 0.
    assign w_start_base = frame ? '0 : r_base;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_trig)    w_state_nxt = FETCH;
                else if (w_hs) w_state_nxt = DRAW;
            end
            DRAW: begin
                if (w_trig)           w_state_nxt = FETCH;
                else if (!draw_valid) w_state_nxt = IDLE;
            end
            FETCH: begin
                if (!w_trig && w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        draw_ready = 1'b0;
        fetch_busy = 1'b0;
        case (r_state)
            IDLE, DRAW: draw_ready = r_run && !w_trig;
            FETCH:      fetch_busy = 1'b1;
            default:    draw_ready = 1'b0;
        endcase
    end

    // Issue stage: base accounting, word counter, and the shared memory port.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_run       <= 1'b0;
            r_err       <= 1'b0;
            r_iss_on    <= 1'b0;
            r_iss_idx   <= '0;
            r_half      <= 1'b0;
            r_base      <= '0;
            r_cur_base  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_vld    <= '0;
            r_lb_we     <= 1'b0;
            r_lb_last   <= 1'b0;
            r_lb_addr   <= '0;
            r_lb_wdata  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_overrun) r_err <= 1'b1;

            // Base advances at trigger time, so an abandoned line's slot is skipped.
            if (w_trig) begin
                r_cur_base <= w_start_base;
                r_base     <= w_start_base + LW_A;
                r_half     <= frame ? 1'b0 : ~sy[0];
            end else if (frame) begin
                r_base <= '0;
            end

            if (w_trig) begin
                r_iss_on  <= 1'b1;
                r_iss_idx <= '0;
            end else if (r_iss_on) begin
                r_iss_idx <= r_iss_idx + LB_ADDRW'(1);
                if (r_iss_idx == LAST_IDX) r_iss_on <= 1'b0;
            end

            r_mem_re <= r_iss_on && !w_trig;
            r_mem_we <= w_hs;
            if (r_iss_on && !w_trig) begin
                r_mem_addr <= r_cur_base + FB_ADDRW'(r_iss_idx);
            end else if (w_hs) begin
                r_mem_addr  <= draw_addr;
                r_mem_wdata <= draw_data;
            end

            // Return stage: a new trigger kills every read still in flight.
            r_rd_vld[0] <= r_mem_re && !w_trig;
            for (int k = 1; k < FETCH_LAT; k++) begin
                r_rd_vld[k] <= r_rd_vld[k-1] && !w_trig;
            end

            r_lb_we <= r_rd_vld[FETCH_LAT-1] && !w_trig;
            if (r_rd_vld[FETCH_LAT-1]) begin
                r_lb_last  <= (r_rd_idx[FETCH_LAT-1] == LAST_IDX);
                r_lb_addr  <= {r_half, r_rd_idx[FETCH_LAT-1]};
                r_lb_wdata <= mem_rdata;
            end else begin
                r_lb_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        r_mem_idx   <= r_iss_idx;
        r_rd_idx[0] <= r_mem_idx;
        for (int k = 1; k < FETCH_LAT; k++) begin
            r_rd_idx[k] <= r_rd_idx[k-1];
        end
    end

    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign lb_we     = r_lb_we;
    assign lb_addr   = r_lb_addr;
    assign lb_wdata  = r_lb_wdata;
    assign fetch_err = r_err;

endmodule

// File: tb/tb_fb_bus_sched.sv
// Directed bench for fb_bus_sched with a small framebuffer and a 1-cycle RAM model.
module tb_fb_bus_sched;

    logic               clk_pix;
    logic               rst_pix_n;
    logic               frame;
    logic               line;
    logic signed [15:0] sy;
    logic               draw_valid;
    logic               draw_ready;
    logic [7:0]         draw_addr;
    logic [7:0]         draw_data;
    logic [7:0]         mem_addr;
    logic               mem_we;
    logic               mem_re;
    logic [7:0]         mem_wdata;
    logic [7:0]         mem_rdata;
    logic               lb_we;
    logic [3:0]         lb_addr;
    logic [7:0]         lb_wdata;
    logic               fetch_busy;
    logic               fetch_err;

    int checks = 0;
    int errors = 0;

    fb_bus_sched #(
        .CORDW(16), .V_RES(4), .LINE_WORDS(8),
        .FB_ADDRW(8), .FB_DATAW(8), .LB_ADDRW(3)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .line(line), .sy(sy),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_addr(draw_addr),
        .draw_data(draw_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
        .lb_wdata(lb_wdata), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    function automatic logic [7:0] ram_f(input logic [7:0] a);
        return a * 8'd7 + 8'd3;
    endfunction

    always @(posedge clk_pix) begin
        if (mem_re) mem_rdata <= ram_f(mem_addr);
    end

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    // Walks a full fetch starting the cycle after the trigger was sampled.
    task automatic expect_fetch(input logic [7:0] base, input logic half, input string tag);
        logic exp_re, exp_lb;
        for (int k = 0; k <= 10; k++) begin
            exp_re = (k >= 1 && k <= 8);
            exp_lb = (k >= 3 && k <= 10);
            checks++;
            if (fetch_busy !== 1'b1) begin
                errors++; $display("FAIL %s busy k=%0d got %b exp 1", tag, k, fetch_busy);
            end
            checks++;
            if (draw_ready !== 1'b0) begin
                errors++; $display("FAIL %s ready k=%0d got %b exp 0", tag, k, draw_ready);
            end
            checks++;
            if (mem_we !== 1'b0) begin
                errors++; $display("FAIL %s mem_we k=%0d got %b exp 0", tag, k, mem_we);
            end
            checks++;
            if (mem_re !== exp_re) begin
                errors++; $display("FAIL %s mem_re k=%0d got %b exp %b", tag, k, mem_re, exp_re);
            end
            if (exp_re) begin
                checks++;
                if (mem_addr !== base + 8'(k - 1)) begin
                    errors++;
                    $display("FAIL %s mem_addr k=%0d got %0d exp %0d", tag, k, mem_addr, base + 8'(k - 1));
                end
            end
            checks++;
            if (lb_we !== exp_lb) begin
                errors++; $display("FAIL %s lb_we k=%0d got %b exp %b", tag, k, lb_we, exp_lb);
            end
            if (exp_lb) begin
                checks++;
                if (lb_addr !== {half, 3'(k - 3)}) begin
                    errors++;
                    $display("FAIL %s lb_addr k=%0d got %0h exp %0h", tag, k, lb_addr, {half, 3'(k - 3)});
                end
                checks++;
                if (lb_wdata !== ram_f(base + 8'(k - 3))) begin
                    errors++;
                    $display("FAIL %s lb_wdata k=%0d got %0h exp %0h", tag, k, lb_wdata, ram_f(base + 8'(k - 3)));
                end
            end
            step();
        end
        checks++;
        if (fetch_busy !== 1'b0 || mem_re !== 1'b0 || lb_we !== 1'b0) begin
            errors++;
            $display("FAIL %s end busy/re/lb got %b%b%b exp 000", tag, fetch_busy, mem_re, lb_we);
        end
    endtask

    task automatic test_reset();
        rst_pix_n = 1'b0;
        step();
        step();
        checks++;
        if ({draw_ready, mem_we, mem_re, lb_we, fetch_busy, fetch_err} !== 6'b0 ||
            mem_addr !== 8'd0 || lb_addr !== 4'd0 || mem_wdata !== 8'd0 || lb_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b re=%b lb=%b busy=%b err=%b exp all 0",
                     draw_ready, mem_we, mem_re, lb_we, fetch_busy, fetch_err);
        end
        rst_pix_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({mem_we, mem_re, lb_we, fetch_busy, fetch_err} !== 5'b0 || draw_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d got rdy=%b we=%b re=%b lb=%b busy=%b err=%b exp rdy=1 rest 0",
                         i, draw_ready, mem_we, mem_re, lb_we, fetch_busy, fetch_err);
            end
        end
    endtask

    task automatic test_frame_fetch();
        frame = 1'b1;
        step();
        frame = 1'b0;
        line  = 1'b1;
        sy    = -16'sd1;
        #1;
        checks++;
        if (draw_ready !== 1'b0) begin
            errors++; $display("FAIL trig_ready got %b exp 0", draw_ready);
        end
        step();
        line = 1'b0;
        expect_fetch(8'd0, 1'b0, "line0");
    endtask

    task automatic test_next_line();
        step();
        line = 1'b1;
        sy   = 16'sd0;
        step();
        line = 1'b0;
        expect_fetch(8'd8, 1'b1, "line1");
        step();
        line = 1'b1;
        sy   = 16'sd3;
        #1;
        checks++;
        if (draw_ready !== 1'b1) begin
            errors++; $display("FAIL no_trig_ready got %b exp 1", draw_ready);
        end
        step();
        line = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetch_busy !== 1'b0 || mem_re !== 1'b0) begin
                errors++; $display("FAIL out_of_range cyc=%0d busy=%b re=%b exp 00", i, fetch_busy, mem_re);
            end
            step();
        end
    endtask

    task automatic test_draw();
        logic [7:0] a;
        draw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 8'd100 + 8'(i);
            draw_addr = a;
            draw_data = 8'hA0 + 8'(i);
            #1;
            checks++;
            if (draw_ready !== 1'b1) begin
                errors++; $display("FAIL draw_ready i=%0d got %b exp 1", i, draw_ready);
            end
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== a || mem_wdata !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL draw_write i=%0d got we=%b re=%b addr=%0d data=%0h exp we=1 re=0 addr=%0d data=%0h",
                         i, mem_we, mem_re, mem_addr, mem_wdata, a, 8'hA0 + 8'(i));
            end
        end
        draw_valid = 1'b0;
        step();
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL draw_idle got we=%b exp 0", mem_we);
        end
        // Burst interrupted by a line trigger.
        draw_valid = 1'b1;
        draw_addr  = 8'd110;
        draw_data  = 8'hB0;
        step();
        draw_addr = 8'd111;
        draw_data = 8'hB1;
        line      = 1'b1;
        sy        = 16'sd1;
        #1;
        checks++;
        if (draw_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'd110) begin
            errors++;
            $display("FAIL trig_mid_burst got rdy=%b we=%b addr=%0d exp rdy=0 we=1 addr=110",
                     draw_ready, mem_we, mem_addr);
        end
        step();
        line = 1'b0;
        expect_fetch(8'd16, 1'b0, "line2_draw");
        for (int i = 1; i < 3; i++) begin
            a = 8'd110 + 8'(i);
            draw_addr = a;
            draw_data = 8'hB0 + 8'(i);
            #1;
            checks++;
            if (draw_ready !== 1'b1) begin
                errors++; $display("FAIL resume_ready i=%0d got %b exp 1", i, draw_ready);
            end
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== 8'hB0 + 8'(i)) begin
                errors++;
                $display("FAIL resume_write i=%0d got we=%b addr=%0d data=%0h exp we=1 addr=%0d data=%0h",
                         i, mem_we, mem_addr, mem_wdata, a, 8'hB0 + 8'(i));
            end
        end
        draw_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_overrun();
        line = 1'b1;
        sy   = 16'sd1;
        step();
        line = 1'b0;
        step();
        step();
        step();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 8'd26 || lb_we !== 1'b1 || lb_addr !== 4'h0 ||
            lb_wdata !== ram_f(8'd24) || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL pre_overrun got re=%b addr=%0d lb=%b lba=%0h lbd=%0h err=%b exp 1 26 1 0 %0h 0",
                     mem_re, mem_addr, lb_we, lb_addr, lb_wdata, fetch_err, ram_f(8'd24));
        end
        line = 1'b1;
        sy   = 16'sd2;
        step();
        line = 1'b0;
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++; $display("FAIL overrun_err got %b exp 1", fetch_err);
        end
        expect_fetch(8'd32, 1'b1, "restart");
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b exp 1", fetch_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        line = 1'b1;
        sy   = 16'sd0;
        step();
        line = 1'b0;
        step();
        step();
        rst_pix_n = 1'b0;
        step();
        checks++;
        if ({draw_ready, mem_we, mem_re, lb_we, fetch_busy, fetch_err} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b we=%b re=%b lb=%b busy=%b err=%b exp all 0",
                     draw_ready, mem_we, mem_re, lb_we, fetch_busy, fetch_err);
        end
        rst_pix_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mem_we, mem_re, lb_we, fetch_busy} !== 4'b0) begin
                errors++;
                $display("FAIL post_reset_quiet cyc=%0d got we=%b re=%b lb=%b busy=%b exp 0",
                         i, mem_we, mem_re, lb_we, fetch_busy);
            end
        end
        line = 1'b1;
        sy   = -16'sd1;
        step();
        line = 1'b0;
        expect_fetch(8'd0, 1'b0, "after_reset");
        step();
        frame = 1'b1;
        line  = 1'b1;
        sy    = 16'sd0;
        step();
        frame = 1'b0;
        line  = 1'b0;
        expect_fetch(8'd0, 1'b0, "frame_and_line");
    endtask

    initial begin
        rst_pix_n  = 1'b0;
        frame      = 1'b0;
        line       = 1'b0;
        sy         = '0;
        draw_valid = 1'b0;
        draw_addr  = '0;
        draw_data  = '0;
        test_reset();
        test_frame_fetch();
        test_next_line();
        test_draw();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
